vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
Parametrised successor to the single-axis zero/threshold counter. Generates a complete VGA raster from one clock: horizontal and vertical counters, each with four-region decode (visible, front porch, sync, back porch), sync polarity control, a pixel clock-enable, and line/frame strobes. It sits between the clock source and the pixel pipeline and frame-buffer read logic of the VGA controller.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level
COUNTER_SIZE, 11, width of both counters and the pixel_x/pixel_y outputs

Ports:
control_clock  input  1  pixel-domain clock
control_reset_n  input  1  asynchronous, active-low reset
pixel_enable  input  1  clock enable; counters and outputs advance only when 1
pixel_x  output  COUNTER_SIZE  horizontal position of the current output cycle
pixel_y  output  COUNTER_SIZE  vertical position of the current output cycle
display_enable  output  1  1 when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
hsync  output  1  horizontal sync at H_SYNC_POL level when active
vsync  output  1  vertical sync at V_SYNC_POL level when active
h_region  output  2  00 visible, 01 front porch, 10 sync, 11 back porch
v_region  output  2  same encoding, vertical axis
line_start  output  1  one-clock strobe, pixel_x became 0
frame_start  output  1  one-clock strobe, pixel_x and pixel_y became 0

Behaviour:
- H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK; V_TOTAL is defined likewise.
- Internal h_cnt and v_cnt count from 0. On an enabled edge, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments. v_cnt wraps to 0 at V_TOTAL-1 when h_cnt wraps.
- Horizontal decode ranges:
  - visible: [0, H_VISIBLE-1]
  - front porch: [H_VISIBLE, H_VISIBLE+H_FRONT-1]
  - sync: [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
  - back porch: the remaining counts up to H_TOTAL-1
- The vertical decode uses the same ranges with the V_ parameters.
- All outputs are registered, with one enabled cycle of latency. On an enabled edge, the output registers load the decode of the pre-increment h_cnt/v_cnt. pixel_x/pixel_y, the syncs, the regions and display_enable are therefore always mutually consistent.
- When pixel_enable = 0, the counters and all level outputs hold their values.
- line_start/frame_start are 1 for exactly one clock after an enabled edge that loaded pixel_x = 0 (and pixel_y = 0 for frame_start). In every other clock they are 0, including disabled cycles.
- Reset values: internal counters 0, pixel_x = 0, pixel_y = 0, display_enable = 0, hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, h_region = v_region = 00, strobes = 0.
- Reset is asynchronous and takes effect immediately, including mid-line or mid-frame. After release, the first enabled edge outputs (0,0) with both strobes set.
- Parameter rules: every porch/sync parameter must be at least 1, and V_TOTAL and H_TOTAL must each fit in 2^COUNTER_SIZE. Violations are reported by $display plus $finish in an initial block.

Optional Feature:
VGA_TIMING_FRAME_COUNT_EN:
- Defined: adds output frame_count [15:0], reset 0. It increments on each enabled edge that sets frame_start and wraps from 65535 to 0. It updates in the same cycle as frame_start.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset released, pixel_enable held at 1 -> first edge gives pixel_x = 0, pixel_y = 0, display_enable = 1, h_region = 00, line_start = 1, frame_start = 1.
- Default params, free run -> hsync = 0 exactly while pixel_x is 656..751 (h_region = 10); display_enable drops at pixel_x = 640; line_start period is 800 clocks.
- Full frame -> frame_start period is 420000 clocks; vsync = 0 only for pixel_y 490..491 (1600 clocks); v_region = 01 for pixel_y 480..489.
- pixel_enable toggled 1/0 every clock -> all periods double (line = 1600 clocks), strobes stay 1 clock wide, outputs are stable in disabled cycles.
- control_reset_n pulsed low asynchronously at pixel_x = 300, pixel_y = 100 -> outputs take reset values before the next clock edge; restart at (0,0) with frame_start = 1.
- Overrides H 800/40/128/88, V 600/1/4/23, both POL = 1 -> hsync = 1 only for pixel_x 840..967, line = 1056 clocks, frame = 628 lines. With VGA_TIMING_FRAME_COUNT_EN defined, frame_count reaches 3 after 3 full frames.

Source files
------------

// File: rtl/vga_timing_generator.sv
// VGA raster timing: h/v counters, region decode, syncs, strobes.
// Optional frame counter output: define VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_generator #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int H_SYNC_POL   = 0,
  parameter int V_SYNC_POL   = 0,
  parameter int COUNTER_SIZE = 11
) (
  input  logic                    control_clock,
  input  logic                    control_reset_n,
  input  logic                    pixel_enable,
  output logic [COUNTER_SIZE-1:0] pixel_x,
  output logic [COUNTER_SIZE-1:0] pixel_y,
  output logic                    display_enable,
  output logic                    hsync,
  output logic                    vsync,
  output logic [1:0]              h_region,
  output logic [1:0]              v_region,
  output logic                    line_start,
  output logic                    frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]             frame_count
`endif
);

  localparam int CW = COUNTER_SIZE;

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_FP =
    CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SY =
    CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_BP =
    CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] H_LAST =
    CW'(H_TOTAL - 1);

  localparam logic [CW-1:0] V_FP =
    CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SY =
    CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_BP =
    CW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CW-1:0] V_LAST =
    CW'(V_TOTAL - 1);

  localparam logic HS_ON  = 1'(H_SYNC_POL);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = 1'(V_SYNC_POL);
  localparam logic VS_OFF = ~VS_ON;

  localparam bit PARAM_BAD =
    (H_FRONT < 1) || (H_SYNC < 1) ||
    (H_BACK < 1)  || (V_FRONT < 1) ||
    (V_SYNC < 1)  || (V_BACK < 1) ||
    (H_TOTAL > (1 << CW)) ||
    (V_TOTAL > (1 << CW));

  localparam logic [1:0] R_VIS  = 2'b00;
  localparam logic [1:0] R_FP   = 2'b01;
  localparam logic [1:0] R_SYNC = 2'b10;
  localparam logic [1:0] R_BP   = 2'b11;

  generate
    if (PARAM_BAD) begin : g_param_err
      initial begin
        $display("vga_timing_generator: bad params");
        $finish;
      end
    end
  endgenerate

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [1:0]    h_reg_d;
  logic [1:0]    v_reg_d;
  logic          hsync_d;
  logic          vsync_d;
  logic          vis_d;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Raster counters, advancing only on enabled cycles.
  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pixel_enable) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Horizontal region of the current count.
  always_comb begin
    h_reg_d = R_BP;
    unique case (1'b1)
      (h_cnt < H_FP):
        h_reg_d = R_VIS;
      (h_cnt >= H_FP && h_cnt < H_SY):
        h_reg_d = R_FP;
      (h_cnt >= H_SY && h_cnt < H_BP):
        h_reg_d = R_SYNC;
      default:
        h_reg_d = R_BP;
    endcase
  end

  // Vertical region of the current count.
  always_comb begin
    v_reg_d = R_BP;
    unique case (1'b1)
      (v_cnt < V_FP):
        v_reg_d = R_VIS;
      (v_cnt >= V_FP && v_cnt < V_SY):
        v_reg_d = R_FP;
      (v_cnt >= V_SY && v_cnt < V_BP):
        v_reg_d = R_SYNC;
      default:
        v_reg_d = R_BP;
    endcase
  end

  // Sync levels and visibility derived from the regions.
  always_comb begin
    hsync_d = (h_reg_d == R_SYNC) ? HS_ON : HS_OFF;
    vsync_d = (v_reg_d == R_SYNC) ? VS_ON : VS_OFF;
    vis_d   = (h_reg_d == R_VIS) &&
              (v_reg_d == R_VIS);
  end

  // Level outputs load the pre-increment decode.
  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      pixel_x        <= '0;
      pixel_y        <= '0;
      display_enable <= 1'b0;
      hsync          <= HS_OFF;
      vsync          <= VS_OFF;
      h_region       <= R_VIS;
      v_region       <= R_VIS;
    end else if (pixel_enable) begin
      pixel_x        <= h_cnt;
      pixel_y        <= v_cnt;
      display_enable <= vis_d;
      hsync          <= hsync_d;
      vsync          <= vsync_d;
      h_region       <= h_reg_d;
      v_region       <= v_reg_d;
    end
  end

  // Strobes live for one clock only, never in held cycles.
  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pixel_enable) begin
      line_start  <= (h_cnt == '0);
      frame_start <= (h_cnt == '0) &&
                     (v_cnt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  // Frame counter, steps together with frame_start.
  always_ff @(posedge control_clock or negedge control_reset_n) begin
    if (!control_reset_n) begin
      frame_count <= '0;
    end else if (pixel_enable &&
                 (h_cnt == '0) &&
                 (v_cnt == '0)) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator on a tiny raster.
// Raster: H 8/2/3/2 (15), V 4/1/2/1 (8), hsync high, vsync low.
module tb_vga_timing_generator;

  localparam int CW = 6;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de;
    logic          hs;
    logic          vs;
    logic [1:0]    hr;
    logic [1:0]    vr;
    logic          ls;
    logic          fs;
    logic [15:0]   fc;
  } out_t;

  typedef struct packed {
    out_t       o;
    logic [1:0] w;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          display_enable;
  logic          hsync;
  logic          vsync;
  logic [1:0]    h_region;
  logic [1:0]    v_region;
  logic          line_start;
  logic          frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0]   frame_count;
`endif

  vga_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2),
    .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1),
    .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(0),
    .COUNTER_SIZE(CW)
  ) dut (
    .control_clock(clk),
    .control_reset_n(rst_n),
    .pixel_enable(en),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .display_enable(display_enable),
    .hsync(hsync),
    .vsync(vsync),
    .h_region(h_region),
    .v_region(v_region),
    .line_start(line_start),
    .frame_start(frame_start)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  item_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          mx = 0;
  int          my = 0;
  logic [15:0] mfc = '0;
  out_t        last;
  out_t        rst_o;
  int          mc = 0;
  int          w_ls[4];
  int          w_fs[4];
  int          w_hs[4];
  int          w_vs[4];
  int          w_de[4];
  int          w_first[4];
  int          w_last[4];

  function automatic logic [1:0] reg_of(
    int c, int vis, int fp, int sy);
    if (c < vis) return 2'b00;
    if (c < vis + fp) return 2'b01;
    if (c < vis + fp + sy) return 2'b10;
    return 2'b11;
  endfunction

  function automatic out_t model(
    int x, int y, logic [15:0] fc);
    out_t o;
    o.x  = CW'(x);
    o.y  = CW'(y);
    o.hr = reg_of(x, 8, 2, 3);
    o.vr = reg_of(y, 4, 1, 2);
    o.de = (x < 8) && (y < 4);
    o.hs = (o.hr == 2'b10);
    o.vs = !(o.vr == 2'b10);
    o.ls = (x == 0);
    o.fs = (x == 0) && (y == 0);
    o.fc = fc;
    return o;
  endfunction

  function automatic out_t act();
    out_t a;
    a.x  = pixel_x;
    a.y  = pixel_y;
    a.de = display_enable;
    a.hs = hsync;
    a.vs = vsync;
    a.hr = h_region;
    a.vr = v_region;
    a.ls = line_start;
    a.fs = frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    a.fc = frame_count;
`else
    a.fc = '0;
`endif
    return a;
  endfunction

  task automatic chk(string n, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d",
               n, got, exp);
    end
  endtask

  task automatic chk_out(string n, out_t e);
    out_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               n, a, e);
    end
  endtask

  task automatic step(input logic e,
                      input logic [1:0] w);
    item_t it;
    @(negedge clk);
    en = e;
    if (e) begin
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (mx == 0 && my == 0) mfc = mfc + 16'd1;
`endif
      last = model(mx, my, mfc);
      if (mx == 14) begin
        mx = 0;
        my = (my == 7) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end else begin
      last.ls = 1'b0;
      last.fs = 1'b0;
    end
    it.o = last;
    it.w = w;
    q.push_back(it);
  endtask

  initial begin
    rst_o = '0;
    rst_o.vs = 1'b1;
    last = rst_o;
    for (int i = 0; i < 4; i++) begin
      w_ls[i] = 0; w_fs[i] = 0;
      w_hs[i] = 0; w_vs[i] = 0;
      w_de[i] = 0;
      w_first[i] = -1; w_last[i] = -1;
    end

    fork
      begin : monitor
        item_t it;
        out_t  a;
        forever begin
          @(posedge clk);
          #1;
          if (q.size() > 0) begin
            it = q.pop_front();
            a = act();
            mc++;
            checks++;
            if (a !== it.o) begin
              errors++;
              $display("FAIL out n=%0d got=%h exp=%h",
                       mc, a, it.o);
            end
            if (it.w != 0) begin
              w_ls[it.w] += int'(a.ls);
              w_fs[it.w] += int'(a.fs);
              w_hs[it.w] += int'(a.hs);
              w_vs[it.w] += int'(!a.vs);
              w_de[it.w] += int'(a.de);
              if (a.ls) begin
                if (w_first[it.w] < 0)
                  w_first[it.w] = mc;
                w_last[it.w] = mc;
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk_out("reset_vals", rst_o);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 2'd1);
    @(posedge clk);
    #2;
    chk("first_fs", int'(frame_start), 1);
    chk("first_de", int'(display_enable), 1);
    for (int i = 1; i < 240; i++)
      step(1'b1, 2'd1);

    for (int i = 0; i < 240; i++) begin
      step(1'b1, 2'd2);
      step(1'b0, 2'd2);
    end

    for (int i = 0; i < 36; i++)
      step(1'b1, 2'd0);
    @(posedge clk);
    #2;
    chk("pre_rst_x", int'(pixel_x), 5);
    chk("pre_rst_y", int'(pixel_y), 2);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("fc_5", int'(frame_count), 5);
`endif
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk_out("async_rst", rst_o);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mx = 0;
    my = 0;
    mfc = '0;
    last = rst_o;

    for (int i = 0; i < 20; i++)
      step(1'b1, 2'd3);
    @(negedge clk);
    en = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    #3;
    chk("drain", q.size(), 0);

    chk("a_ls", w_ls[1], 16);
    chk("a_fs", w_fs[1], 2);
    chk("a_hs", w_hs[1], 48);
    chk("a_vs", w_vs[1], 60);
    chk("a_de", w_de[1], 64);
    chk("a_line_span", w_last[1] - w_first[1], 225);
    chk("b_ls", w_ls[2], 16);
    chk("b_fs", w_fs[2], 2);
    chk("b_hs", w_hs[2], 96);
    chk("b_vs", w_vs[2], 120);
    chk("b_de", w_de[2], 128);
    chk("b_line_span", w_last[2] - w_first[2], 450);
    chk("d_fs", w_fs[3], 1);
    chk("d_ls", w_ls[3], 2);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
